// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises reset_n deassertion, holds every domain in reset for a
// minimum time, then releases the domains one by one, lowest index first.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_DOMAINS = 4,
    parameter int MIN_ASSERT  = 16,
    parameter int GAP_CYCLES  = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   test_mode,
    input  logic                   sw_rst_req,
    output logic [NUM_DOMAINS-1:0] reset_sync_n,
    output logic                   seq_done,
    output logic                   busy
);

    localparam int CNT_MAX = (MIN_ASSERT > GAP_CYCLES) ? MIN_ASSERT : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] ASSERT_LAST = CW'(MIN_ASSERT - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1'b1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                   state_r;
    logic [SYNC_STAGES-1:0]   sync_r;
    logic [CW-1:0]            cnt_r;
    logic [NUM_DOMAINS-1:0]   rel_r;
    logic                     done_r;
    logic                     rst_s;
    logic                     rst_edge_s;
    logic [NUM_DOMAINS-1:0]   rel_next_s;
    logic                     rel_last_s;

    // Thermometer step: one more domain out of reset, always the next-higher index.
    function automatic logic [NUM_DOMAINS-1:0] next_mask(input logic [NUM_DOMAINS-1:0] m);
        return (m << 1) | NUM_DOMAINS'(1'b1);
    endfunction

    assign rst_s      = sync_r[SYNC_STAGES-1];
    // ASSERT is entered on the edge that raises rst_s, so MIN_ASSERT counts from the release.
    assign rst_edge_s = sync_r[SYNC_STAGES-2] | rst_s;
    assign rel_next_s = next_mask(rel_r);
    assign rel_last_s = &rel_next_s;

    // Deassertion synchroniser for reset_n; assertion stays asynchronous.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Sequencing FSM with registered per-domain resets and completion flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= HOLD;
            cnt_r   <= '0;
            rel_r   <= '0;
            done_r  <= 1'b0;
        end else if (sw_rst_req && (state_r != HOLD)) begin
            // Software request wins over any release due on this edge.
            state_r <= ASSERT;
            cnt_r   <= '0;
            rel_r   <= '0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                HOLD: begin
                    cnt_r  <= '0;
                    rel_r  <= '0;
                    done_r <= 1'b0;
                    if (rst_edge_s) begin
                        state_r <= ASSERT;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                ASSERT: begin
                    if (cnt_r == ASSERT_LAST) begin
                        cnt_r <= '0;
                        rel_r <= rel_next_s;
                        if (rel_last_s) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= RELEASE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (cnt_r == GAP_LAST) begin
                        cnt_r <= '0;
                        rel_r <= rel_next_s;
                        if (rel_last_s) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= RELEASE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    state_r <= DONE;
                    cnt_r   <= '0;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= HOLD;
                    cnt_r   <= '0;
                    rel_r   <= '0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Scan bypass hands reset_n straight to every domain; the FSM keeps running underneath.
    assign reset_sync_n = test_mode ? {NUM_DOMAINS{reset_n}} : rel_r;
    assign seq_done     = test_mode ? reset_n : done_r;
    assign busy         = ~seq_done;

    reset_sequencer_checker #(
        .NUM_DOMAINS (NUM_DOMAINS)
    ) u_checker (
        .clk          (clk),
        .reset_n      (reset_n),
        .test_mode    (test_mode),
        .reset_sync_n (reset_sync_n),
        .seq_done     (seq_done),
        .busy         (busy)
    );

endmodule

// Output invariants of the reset sequencer.
module reset_sequencer_checker #(
    parameter int NUM_DOMAINS = 4
) (
    input logic                   clk,
    input logic                   reset_n,
    input logic                   test_mode,
    input logic [NUM_DOMAINS-1:0] reset_sync_n,
    input logic                   seq_done,
    input logic                   busy
);

    a_busy_inv: assert property (@(posedge clk) busy == ~seq_done);

    // Released domains always form a contiguous run starting at bit 0.
    a_thermometer: assert property (@(posedge clk) disable iff (!reset_n || test_mode)
        ((reset_sync_n & (reset_sync_n + NUM_DOMAINS'(1'b1))) == '0));

    a_done_all: assert property (@(posedge clk) disable iff (!reset_n || test_mode)
        seq_done == (&reset_sync_n));

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a per-edge reference model pushes expected outputs,
// a negedge monitor pops and compares.
module tb_reset_sequencer;

    localparam int SS  = 2;
    localparam int ND  = 4;
    localparam int MA  = 16;
    localparam int GAP = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          test_mode;
    logic          sw_rst_req;
    logic [ND-1:0] reset_sync_n;
    logic          seq_done;
    logic          busy;

    reset_sequencer #(
        .SYNC_STAGES (SS),
        .NUM_DOMAINS (ND),
        .MIN_ASSERT  (MA),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .test_mode    (test_mode),
        .sw_rst_req   (sw_rst_req),
        .reset_sync_n (reset_sync_n),
        .seq_done     (seq_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            edge_no;
        logic [ND-1:0] rsn;
        logic          done;
    } exp_t;

    exp_t sb_q[$];
    int   tests    = 0;
    int   fails    = 0;
    int   e_m      = 0;   // edges since reset_n release (edge 1 = first with reset_n high)
    int   anchor_m = SS;  // edge at which the current MIN_ASSERT window started
    bit   active   = 1'b0;

    // Domains out of reset: first at anchor+MA, then one every GAP edges.
    function automatic int released();
        int r;
        if (e_m < anchor_m + MA) begin
            r = 0;
        end else begin
            r = 1 + (e_m - anchor_m - MA) / GAP;
            if (r > ND) r = ND;
        end
        return r;
    endfunction

    // One clock edge: advance the model with the inputs sampled there, then apply new inputs.
    task automatic step(input logic rn, input logic sw, input logic tm);
        exp_t x;
        int   r;
        @(posedge clk);
        if (reset_n) begin
            e_m++;
            if (sw_rst_req && (e_m > SS)) anchor_m = e_m;
        end else begin
            e_m      = 0;
            anchor_m = SS;
        end
        #2;
        reset_n    = rn;
        sw_rst_req = sw;
        test_mode  = tm;
        x.edge_no  = e_m;
        if (tm) begin
            x.rsn  = {ND{rn}};
            x.done = rn;
        end else if (!rn) begin
            x.rsn  = '0;
            x.done = 1'b0;
        end else begin
            r = released();
            for (int k = 0; k < ND; k++) x.rsn[k] = (k < r);
            x.done = (r == ND);
        end
        sb_q.push_back(x);
        active = 1'b1;
    endtask

    task automatic go_until(input int t);
        while (e_m < t) step(1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: one comparison per cycle, away from the active edge.
    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (active) begin
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_empty: no expected entry at time %0t", $time);
                end else begin
                    x = sb_q.pop_front();
                    if (reset_sync_n !== x.rsn || seq_done !== x.done || busy !== ~x.done) begin
                        fails++;
                        $display("FAIL outputs after edge %0d: got rsn=%b done=%b busy=%b, expected rsn=%b done=%b busy=%b",
                                 x.edge_no, reset_sync_n, seq_done, busy, x.rsn, x.done, ~x.done);
                    end
                end
            end
        end
    end

    initial begin : driver
        logic rn, sw, tm;
        reset_n    = 1'b0;
        sw_rst_req = 1'b0;
        test_mode  = 1'b0;

        // Power-on: reset_n rises before edge 1; releases at 18, 26, 34, 42.
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        go_until(60);

        // Single-edge software request at edge 70 while DONE.
        go_until(68);
        step(1'b1, 1'b1, 1'b0);
        go_until(120);

        // Software request at edge 30 during RELEASE.
        repeat (2) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        go_until(28);
        step(1'b1, 1'b1, 1'b0);
        go_until(60);

        // Async reset between edges 28 and 29, then restart.
        repeat (2) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        go_until(27);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        // Request held high for edges 50..60.
        go_until(48);
        repeat (11) step(1'b1, 1'b1, 1'b0);
        go_until(90);

        // Scan bypass with reset_n toggling.
        step(1'b1, 1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b1);
        repeat (4) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        go_until(50);

        // Randomised traffic: rare resets, occasional requests, sticky test_mode.
        tm = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            rn = ($urandom_range(0, 199) != 0);
            sw = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 99) == 0) tm = ~tm;
            step(rn, sw, tm);
        end
        step(1'b1, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
